// File: rtl/alu_operand_sequencer_if.sv
// Bus between the operator front-end (master) and the operand sequencer (slave).
interface alu_operand_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int NOPS  = 2,
  parameter int OPW   = 4
);
  logic [WIDTH-1:0]      data;
  logic                  enter;
  logic                  back;
  logic                  cal_done;
  logic [NOPS*WIDTH-1:0] operands;
  logic [OPW-1:0]        op;
  logic                  do_cal;
  logic                  show_flag;
  logic                  timeout_err;
  logic [2:0]            stage;
  logic [1:0]            idx;

  modport master (
    output data, enter, back, cal_done,
    input  operands, op, do_cal, show_flag, timeout_err, stage, idx
  );

  modport slave (
    input  data, enter, back, cal_done,
    output operands, op, do_cal, show_flag, timeout_err, stage, idx
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects NOPS operands plus an opcode via enter/back strobes, pulses do_cal,
// then waits (bounded) for ALU completion and holds SHOW until acknowledged.
module alu_operand_sequencer #(
  parameter int WIDTH   = 16,
  parameter int NOPS    = 2,
  parameter int OPW     = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_operand_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    OPSEL = 3'd1,
    CALC  = 3'd2,
    WAIT  = 3'd3,
    SHOW  = 3'd4
  } state_t;

  localparam logic [1:0]  LAST = 2'(NOPS - 1);
  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

  state_t                     state, state_d;
  logic [1:0]                 idx, idx_d;
  logic [15:0]                cnt, cnt_d;
  logic                       terr, terr_d;
  logic                       wr_opnd, wr_op;
  logic [NOPS-1:0][WIDTH-1:0] opnd;
  logic [OPW-1:0]             op_q;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    terr_d  = terr;
    wr_opnd = 1'b0;
    wr_op   = 1'b0;
    case (state)
      // back always outranks enter in the same cycle
      LOAD: begin
        if (bus.back) begin
          if (idx != 2'd0) idx_d = idx - 2'd1;
        end else if (bus.enter) begin
          wr_opnd = 1'b1;
          if (idx < LAST) idx_d = idx + 2'd1;
          else            state_d = OPSEL;
        end
      end
      OPSEL: begin
        if (bus.back) begin
          state_d = LOAD;
          idx_d   = LAST;
        end else if (bus.enter) begin
          wr_op   = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        cnt_d   = 16'd0;
        terr_d  = 1'b0;
        state_d = bus.cal_done ? SHOW : WAIT;
      end
      // completion beats a timeout landing on the same cycle
      WAIT: begin
        if (bus.cal_done) begin
          state_d = SHOW;
          terr_d  = 1'b0;
        end else if (cnt == TLIM) begin
          state_d = SHOW;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      SHOW: begin
        if (bus.back) begin
          state_d = OPSEL;
          terr_d  = 1'b0;
        end else if (bus.enter) begin
          state_d = LOAD;
          idx_d   = 2'd0;
          terr_d  = 1'b0;
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = 2'd0;
        cnt_d   = 16'd0;
        terr_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      idx   <= 2'd0;
      cnt   <= 16'd0;
      terr  <= 1'b0;
      opnd  <= '0;
      op_q  <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      terr  <= terr_d;
      if (wr_op) op_q <= bus.data[OPW-1:0];
      for (int k = 0; k < NOPS; k++)
        if (wr_opnd && idx == 2'(k)) opnd[k] <= bus.data;
    end
  end

  assign bus.operands    = opnd;
  assign bus.op          = op_q;
  assign bus.do_cal      = (state == CALC);
  assign bus.show_flag   = (state == SHOW);
  assign bus.timeout_err = terr;
  assign bus.stage       = state;
  assign bus.idx         = idx;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: a NOPS=2/TIMEOUT=8 instance driven from a vector table plus
// hand sequences, and a NOPS=1/WIDTH=8 instance for the single-operand path.
module tb_alu_operand_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_sequencer_if #(.WIDTH(16), .NOPS(2), .OPW(4)) b0 ();
  alu_operand_sequencer_if #(.WIDTH(8),  .NOPS(1), .OPW(4)) b1 ();

  alu_operand_sequencer #(.WIDTH(16), .NOPS(2), .OPW(4), .TIMEOUT(8)) u0 (
    .clk(clk), .rst(rst), .bus(b0));
  alu_operand_sequencer #(.WIDTH(8), .NOPS(1), .OPW(4), .TIMEOUT(8)) u1 (
    .clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    logic        en, bk, cd;
    logic [15:0] d;
    logic [2:0]  stg;
    logic [1:0]  ix;
    logic [31:0] ops;
    logic [3:0]  op;
    logic        dc, sh, te;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk0(input string t, input logic [2:0] stg, input logic [1:0] ix,
                      input logic [31:0] ops, input logic [3:0] op,
                      input logic dc, input logic sh, input logic te);
    chk({t, ".stage"},    32'(b0.stage),       32'(stg));
    chk({t, ".idx"},      32'(b0.idx),         32'(ix));
    chk({t, ".operands"}, b0.operands,         ops);
    chk({t, ".op"},       32'(b0.op),          32'(op));
    chk({t, ".do_cal"},   32'(b0.do_cal),      32'(dc));
    chk({t, ".show"},     32'(b0.show_flag),   32'(sh));
    chk({t, ".terr"},     32'(b0.timeout_err), 32'(te));
  endtask

  task automatic r(input logic en, input logic bk, input logic cd, input logic [15:0] d,
                   input logic [2:0] stg, input logic [1:0] ix, input logic [31:0] ops,
                   input logic [3:0] op, input logic dc, input logic sh, input logic te);
    vec_t v;
    v.en = en; v.bk = bk; v.cd = cd; v.d = d;
    v.stg = stg; v.ix = ix; v.ops = ops; v.op = op;
    v.dc = dc; v.sh = sh; v.te = te;
    tbl.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic en, input logic bk, input logic cd, input logic [15:0] d);
    b0.enter = en; b0.back = bk; b0.cal_done = cd; b0.data = d;
  endtask

  task automatic to_calc(input logic [15:0] a, input logic [15:0] b, input logic [15:0] o);
    drv0(1, 0, 0, a); cyc();
    drv0(1, 0, 0, b); cyc();
    drv0(1, 0, 0, o); cyc();
    drv0(0, 0, 0, 16'h0);
  endtask

  initial begin
    int cnt;
    int pulses;
    drv0(0, 0, 0, 16'h0);
    b1.enter = 0; b1.back = 0; b1.cal_done = 0; b1.data = 8'h0;

    // main flow: two operands, opcode, completion three cycles after do_cal
    r(1,0,0,16'h1234, 0,1,32'h0000_1234,4'h0, 0,0,0);
    r(1,0,0,16'h00FF, 1,1,32'h00FF_1234,4'h0, 0,0,0);
    r(1,0,0,16'h0003, 2,1,32'h00FF_1234,4'h3, 1,0,0);
    r(0,0,0,16'h0000, 3,1,32'h00FF_1234,4'h3, 0,0,0);
    r(0,0,0,16'h0000, 3,1,32'h00FF_1234,4'h3, 0,0,0);
    r(0,0,0,16'h0000, 3,1,32'h00FF_1234,4'h3, 0,0,0);
    r(0,0,1,16'h0000, 4,1,32'h00FF_1234,4'h3, 0,1,0);
    r(0,0,0,16'h0000, 4,1,32'h00FF_1234,4'h3, 0,1,0);
    r(1,0,0,16'h0000, 0,0,32'h00FF_1234,4'h3, 0,0,0);
    // step-back in LOAD and OPSEL
    r(1,0,0,16'hAAAA, 0,1,32'h00FF_AAAA,4'h3, 0,0,0);
    r(0,1,0,16'h0000, 0,0,32'h00FF_AAAA,4'h3, 0,0,0);
    r(1,0,0,16'h5555, 0,1,32'h00FF_5555,4'h3, 0,0,0);
    r(1,1,0,16'h9999, 0,0,32'h00FF_5555,4'h3, 0,0,0);
    r(0,1,0,16'h0000, 0,0,32'h00FF_5555,4'h3, 0,0,0);
    r(1,0,0,16'h1111, 0,1,32'h00FF_1111,4'h3, 0,0,0);
    r(1,0,0,16'h2222, 1,1,32'h2222_1111,4'h3, 0,0,0);
    r(0,1,0,16'h0000, 0,1,32'h2222_1111,4'h3, 0,0,0);
    r(1,0,0,16'h3333, 1,1,32'h3333_1111,4'h3, 0,0,0);
    r(1,0,0,16'h00A5, 2,1,32'h3333_1111,4'h5, 1,0,0);
    // strobes in CALC/WAIT are ignored; timeout after 8 WAIT cycles
    r(1,1,0,16'hBEEF, 3,1,32'h3333_1111,4'h5, 0,0,0);
    for (int i = 0; i < 7; i++)
      r(i == 0, i == 1, 0, 16'hBEEF, 3,1,32'h3333_1111,4'h5, 0,0,0);
    r(0,0,0,16'h0000, 4,1,32'h3333_1111,4'h5, 0,1,1);
    r(0,1,0,16'h0000, 1,1,32'h3333_1111,4'h5, 0,0,0);
    r(1,0,0,16'h0007, 2,1,32'h3333_1111,4'h7, 1,0,0);
    r(0,0,0,16'h0000, 3,1,32'h3333_1111,4'h7, 0,0,0);
    for (int i = 0; i < 7; i++)
      r(0,0,0,16'h0000, 3,1,32'h3333_1111,4'h7, 0,0,0);
    // completion on the last WAIT cycle beats the timeout
    r(0,0,1,16'h0000, 4,1,32'h3333_1111,4'h7, 0,1,0);
    r(1,0,0,16'h0000, 0,0,32'h3333_1111,4'h7, 0,0,0);

    repeat (3) cyc();
    rst = 1'b0;
    chk0("reset", 0, 0, 32'h0, 4'h0, 0, 0, 0);
    chk("reset.u1_ops", 32'(b1.operands), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drv0(tbl[i].en, tbl[i].bk, tbl[i].cd, tbl[i].d);
      cyc();
      chk0($sformatf("vec%0d", i), tbl[i].stg, tbl[i].ix, tbl[i].ops, tbl[i].op,
           tbl[i].dc, tbl[i].sh, tbl[i].te);
    end
    drv0(0, 0, 0, 16'h0);

    // minimum calculation: cal_done concurrent with do_cal
    to_calc(16'h0001, 16'h0002, 16'h0004);
    chk("min.do_cal_c1", 32'(b0.do_cal), 32'h1);
    drv0(0, 0, 1, 16'h0); cyc();
    chk("min.show_c2", 32'(b0.show_flag), 32'h1);
    chk("min.do_cal_c2", 32'(b0.do_cal), 32'h0);
    chk("min.terr", 32'(b0.timeout_err), 32'h0);
    drv0(0, 0, 0, 16'h0); cyc();
    chk("min.show_c3", 32'(b0.show_flag), 32'h1);
    drv0(1, 0, 0, 16'h0); cyc();
    drv0(0, 0, 0, 16'h0);

    // timeout latency measured from the first WAIT cycle, then acknowledge
    to_calc(16'h0010, 16'h0020, 16'h0001);
    cyc();
    chk("to.first_wait", 32'(b0.stage), 32'd3);
    cnt = 0; pulses = 0;
    while (!b0.show_flag && cnt < 50) begin
      cyc();
      cnt++;
      if (b0.do_cal) pulses++;
    end
    chk("to.latency", 32'(cnt), 32'd8);
    chk("to.no_do_cal", 32'(pulses), 32'd0);
    chk("to.terr", 32'(b0.timeout_err), 32'h1);
    drv0(1, 0, 0, 16'h0); cyc();
    drv0(0, 0, 0, 16'h0);
    chk("to.ack_stage", 32'(b0.stage), 32'd0);
    chk("to.ack_terr", 32'(b0.timeout_err), 32'h0);
    chk("to.ack_idx", 32'(b0.idx), 32'd0);

    // reset mid-WAIT, with strobes asserted alongside it
    to_calc(16'h0BAD, 16'h0CAB, 16'h0009);
    cyc(); cyc();
    chk("rw.in_wait", 32'(b0.stage), 32'd3);
    rst = 1'b1; drv0(1, 1, 1, 16'hFFFF); cyc();
    chk0("rw", 0, 0, 32'h0, 4'h0, 0, 0, 0);
    rst = 1'b0; drv0(0, 0, 0, 16'h0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      b0.cal_done = i[0];
      cyc();
      if (b0.do_cal) pulses++;
    end
    b0.cal_done = 1'b0;
    chk("rw.no_do_cal", 32'(pulses), 32'd0);
    chk("rw.stage", 32'(b0.stage), 32'd0);

    // single-operand instance
    b1.enter = 1; b1.data = 8'h7F; cyc();
    chk("n1.stage", 32'(b1.stage), 32'd1);
    chk("n1.idx", 32'(b1.idx), 32'd0);
    chk("n1.ops", 32'(b1.operands), 32'h7F);
    b1.data = 8'h02; cyc();
    b1.enter = 0;
    chk("n1.op", 32'(b1.op), 32'h2);
    chk("n1.do_cal", 32'(b1.do_cal), 32'h1);
    chk("n1.ops_kept", 32'(b1.operands), 32'h7F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Parametrised front-end sequencer for the ALU test harness. It collects `NOPS` operands and one opcode from a shared input bus, one field per `enter` strobe, and fires a one-cycle calculate pulse. It then waits for the ALU's completion with a bounded timeout and holds a show-flags phase until the operator acknowledges it. It sits between the switch/debounce front-end and the ALU core, and generalises the fixed two-operand free-running input FSM with explicit strobes, step-back, variable operand count and completion handshaking.

## Interface
- `WIDTH`, 16, operand and input bus width (4..32)
- `NOPS`, 2, number of operands collected per calculation (1..4)
- `OPW`, 4, opcode width, taken from `data[OPW-1:0]` (OPW ≤ WIDTH)
- `TIMEOUT`, 255, maximum cycles spent in WAIT before forcing SHOW (1..65535)

- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `data`  in  WIDTH  shared operand/opcode input bus
- `enter`  in  1  single-cycle strobe: accept current field / acknowledge SHOW
- `back`  in  1  single-cycle strobe: step to previous field
- `cal_done`  in  1  ALU completion, level or pulse
- `operands`  out  NOPS*WIDTH  operand k at bits [k*WIDTH +: WIDTH]
- `op`  out  OPW  latched opcode
- `do_cal`  out  1  one-cycle calculate pulse
- `show_flag`  out  1  high throughout SHOW
- `timeout_err`  out  1  high in SHOW when entered via timeout
- `stage`  out  3  current state code (for display)
- `idx`  out  2  operand index currently being loaded

## Operation
- States and `stage` codes: LOAD=0, OPSEL=1, CALC=2, WAIT=3, SHOW=4. Codes 5..7 are unreachable. If an illegal code is ever reached, the next state is LOAD with idx 0.
- LOAD: on `enter`, operand[idx] <= `data`. If idx < NOPS-1, idx increments. Otherwise the state goes to OPSEL.
- OPSEL: on `enter`, `op` <= `data[OPW-1:0]` and the state goes to CALC.
- CALC: lasts exactly one cycle with `do_cal`=1. The timeout counter clears. If `cal_done`=1 in this cycle, next state is SHOW, otherwise WAIT.
- WAIT: the counter increments each cycle.
  - `cal_done`=1 → SHOW with `timeout_err`=0.
  - Counter reaching TIMEOUT-1 without `cal_done` → SHOW with `timeout_err`=1.
  - If both occur in the same cycle, `cal_done` wins (`timeout_err`=0).
- SHOW: `show_flag`=1. On `enter`, the state goes to LOAD with idx 0, and `show_flag` and `timeout_err` clear. Operands and op are retained, so a field can be re-entered unchanged.
- back in LOAD with idx>0: idx-1. back in LOAD with idx 0: no effect.
- back in OPSEL: LOAD with idx NOPS-1. back in SHOW: OPSEL, flags clear.
- `enter` and `back` are both ignored in CALC and WAIT.
- `enter` and `back` in the same cycle: `back` wins and `enter` is discarded.
- Any field written with `data` latches the value present on the strobe cycle.
- NOPS=1: idx stays 0, and LOAD `enter` goes directly to OPSEL.

## Timing
- All outputs are registered, and `do_cal`, `show_flag` and `stage` are decoded from the state register.
- Reset values: state LOAD, idx 0, operands 0, op 0, `do_cal` 0, `show_flag` 0, `timeout_err` 0, `stage` 0, counter 0.
- `rst` has priority over every strobe in the same cycle. A reset asserted during CALC, WAIT or SHOW returns to LOAD on the next edge with no further `do_cal`.
- Latency rules:
  - `enter` in OPSEL → `do_cal` high in the following cycle.
  - `cal_done` in cycle N → `show_flag` high at N+1.
- Minimum calculation (cal_done concurrent with `do_cal`): the OPSEL `enter` is at cycle 0, `do_cal` at cycle 1, and `show_flag` from cycle 2.
- Timeout case: SHOW is entered exactly TIMEOUT cycles after the first WAIT cycle.
- `do_cal` is never high for more than one consecutive cycle.

## Test plan
- Reset, then NOPS=2: `enter` with data=0x1234, then 0x00FF, then 0x0003. Required: operands={0x00FF,0x1234}, op=3, a single `do_cal` pulse, and with `cal_done` pulsed 3 cycles later, `show_flag`=1 and `timeout_err`=0.
- Step-back:
  - load 0xAAAA, then assert `back`, then load 0x5555. Required: operand0=0x5555, idx=0→1 afterwards.
  - `back` in OPSEL. Required: idx=NOPS-1, stage=0.
- Timeout with TIMEOUT=8 and `cal_done` held 0. Required: SHOW reached 8 cycles after WAIT entry, `timeout_err`=1; `enter` then gives stage=0 and `timeout_err`=0.
- Simultaneous events:
  - `enter`+`back` in LOAD idx 1. Required: idx→0 with no write.
  - `cal_done` on the final WAIT cycle. Required: `timeout_err`=0.
- Reset mid-WAIT. Required: next cycle all outputs at reset values and no `do_cal` afterwards; strobes held in CALC/WAIT cause no state change.
- NOPS=1, WIDTH=8: `enter` 0x7F then op 0x2. Required: OPSEL reached after one `enter` and operands=0x7F.
